// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int XLEN = 32;

  // addi x0,x0,0: the bubble word presented when no real instruction is delivered
  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            valid;
  } fetch_slot_t;

  // Sequential successor of a PC; wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/fetch_hold_buffer.sv
// One-entry skid buffer that parks a fetched word while the decode stage is stalled.
module fetch_hold_buffer
  import fetch_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic            drain_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] instr_o,
  output logic            full_o
);

  fetch_slot_t slot_q, slot_d;

  // Next entry: a flush wins over a load, a load wins over a drain.
  always_comb begin
    slot_d = slot_q;
    if (flush_i) begin
      slot_d.valid = 1'b0;
    end else if (load_i) begin
      slot_d = '{pc: pc_i, instr: instr_i, valid: 1'b1};
    end else if (drain_i) begin
      slot_d.valid = 1'b0;
    end
  end

  // Entry register, emptied by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_q <= '{pc: '0, instr: '0, valid: 1'b0};
    end else begin
      slot_q <= slot_d;
    end
  end

  assign pc_o    = slot_q.pc;
  assign instr_o = slot_q.instr;
  assign full_o  = slot_q.valid;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one-outstanding imem requests and
// drives the IF/ID slot. Handles stalls (via the hold buffer), branch redirects
// (bubble + discard of the in-flight response) and variable memory latency.
// Optional: define FETCH_PERF_CNT_EN to add fetch_count / bubble_count outputs.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_out,
  output logic [31:0] PC4_out,
  output logic [31:0] instruction_out,
  output logic        valid_out
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count
`endif
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  fetch_slot_t     out_q, out_d;
  fetch_slot_t     load_slot;
  logic            load_valid;
  logic            load_bubble;

  logic            buf_load;
  logic            buf_drain;
  logic            buf_flush;
  logic            buf_full;
  logic [XLEN-1:0] buf_pc;
  logic [XLEN-1:0] buf_instr;

  fetch_hold_buffer u_hold_buffer (
    .clk_i   (CLK),
    .rst_ni  (RESETn),
    .load_i  (buf_load),
    .pc_i    (pc_q),
    .instr_i (imem_rdata),
    .drain_i (buf_drain),
    .flush_i (buf_flush),
    .pc_o    (buf_pc),
    .instr_o (buf_instr),
    .full_o  (buf_full)
  );

  // Next-state, next-PC and IF/ID slot selection; a taken branch overrides everything.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_load    = 1'b0;
    buf_drain   = 1'b0;
    buf_flush   = 1'b0;
    load_valid  = 1'b0;
    load_bubble = 1'b0;
    load_slot   = '{pc: pc_q, instr: imem_rdata, valid: 1'b1};

    if (BRANCH_TAKEN) begin
      pc_d      = BRANCH_TARGET & ~32'h0000_0003;
      buf_flush = 1'b1;
      case (state_q)
        FETCH: begin
          load_bubble = 1'b1;
          // A response arriving this cycle is simply dropped; otherwise it is
          // still in flight and must be drained before the next request.
          state_d = imem_rvalid ? FETCH : DRAIN;
        end
        HOLD: begin
          load_bubble = 1'b1;
          state_d     = FETCH;
        end
        DRAIN: begin
          // Slot already holds a bubble; only the PC moves. If the awaited
          // response lands now, it is the one being drained.
          state_d = imem_rvalid ? FETCH : DRAIN;
        end
        default: state_d = FETCH;
      endcase
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_rvalid) begin
            pc_d = pc_plus4(pc_q);
            if (STALL) begin
              buf_load = 1'b1;
              state_d  = HOLD;
            end else begin
              load_valid = 1'b1;
            end
          end else if (!STALL) begin
            load_bubble = 1'b1;
          end
        end
        HOLD: begin
          if (!STALL && buf_full) begin
            load_valid = 1'b1;
            load_slot  = '{pc: buf_pc, instr: buf_instr, valid: 1'b1};
            buf_drain  = 1'b1;
            state_d    = FETCH;
          end
        end
        DRAIN: begin
          if (imem_rvalid) begin
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end

    // A bubble keeps the last PC so PC_out/PC4_out do not move.
    if (load_valid) begin
      out_d = load_slot;
    end else if (load_bubble) begin
      out_d = '{pc: out_q.pc, instr: NOP_INSTR, valid: 1'b0};
    end else begin
      out_d = out_q;
    end
  end

  // State, PC and IF/ID slot registers.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      out_q   <= '{pc: RESET_PC, instr: NOP_INSTR, valid: 1'b0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
    end
  end

  // Request is masked during reset so it first rises once RESETn is released.
  assign imem_req        = RESETn && (state_q == FETCH);
  assign imem_addr       = pc_q;
  assign PC_out          = out_q.pc;
  assign PC4_out         = pc_plus4(out_q.pc);
  assign instruction_out = out_q.instr;
  assign valid_out       = out_q.valid;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] bubble_cnt_q;

  // Count delivered instructions and loaded bubbles; both wrap freely.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (load_valid) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (load_bubble) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_count  = fetch_cnt_q;
  assign bubble_count = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed testbench for instruction_fetch_unit: a vector table walks through
// zero latency, long latency, stall/hold, branch/drain and branch-in-hold; hand
// sequences cover PC wrap and an asynchronous reset pulse during DRAIN.
module tb_instruction_fetch_unit;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        STALL = 1'b0;
  logic        BRANCH_TAKEN = 1'b0;
  logic [31:0] BRANCH_TARGET = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] PC_out, PC4_out, instruction_out;
  logic        valid_out;

  // second instance with a wrapping reset PC and a zero-latency memory
  logic        w_req;
  logic [31:0] w_addr, w_rdata, w_pc, w_pc4, w_instr;
  logic        w_valid;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fcnt, bcnt, w_fcnt, w_bcnt;
`endif

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 CLK = ~CLK;

  function automatic logic [31:0] instr_at(input logic [31:0] a);
    if (a == 32'h0) return 32'h00A0_0093;
    return {a[23:0], 8'h13};
  endfunction

  // Memory model: answers after mem_wait request cycles with no response.
  int unsigned mem_wait = 0;
  logic        busy_q;
  int unsigned cnt_q;
  logic [31:0] addr_q;

  assign imem_rvalid = (imem_req || busy_q) && (cnt_q == mem_wait);
  assign imem_rdata  = instr_at(busy_q ? addr_q : imem_addr);

  always @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      busy_q <= 1'b0;
      cnt_q  <= 0;
      addr_q <= 32'h0;
    end else if (imem_req || busy_q) begin
      if (imem_rvalid) begin
        busy_q <= 1'b0;
        cnt_q  <= 0;
      end else begin
        if (!busy_q) addr_q <= imem_addr;
        busy_q <= 1'b1;
        cnt_q  <= cnt_q + 1;
      end
    end
  end

  assign w_rdata = instr_at(w_addr);

  instruction_fetch_unit u_dut (
    .CLK             (CLK),
    .RESETn          (RESETn),
    .STALL           (STALL),
    .BRANCH_TAKEN    (BRANCH_TAKEN),
    .BRANCH_TARGET   (BRANCH_TARGET),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .PC_out          (PC_out),
    .PC4_out         (PC4_out),
    .instruction_out (instruction_out),
    .valid_out       (valid_out)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count     (fcnt),
    .bubble_count    (bcnt)
`endif
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .CLK             (CLK),
    .RESETn          (RESETn),
    .STALL           (1'b0),
    .BRANCH_TAKEN    (1'b0),
    .BRANCH_TARGET   (32'h0),
    .imem_req        (w_req),
    .imem_addr       (w_addr),
    .imem_rvalid     (w_req),
    .imem_rdata      (w_rdata),
    .PC_out          (w_pc),
    .PC4_out         (w_pc4),
    .instruction_out (w_instr),
    .valid_out       (w_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count     (w_fcnt),
    .bubble_count    (w_bcnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    int unsigned wait_c;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        vld;
    logic        req;
    logic [31:0] addr;
  } vec_t;

  localparam int NV = 29;
  localparam logic [31:0] NOP = 32'h0000_0013;
  vec_t vt [NV];

  function automatic vec_t mk(input logic s, input logic b, input logic [31:0] t,
                              input int unsigned w, input logic [31:0] pc,
                              input logic [31:0] ins, input logic v,
                              input logic r, input logic [31:0] a);
    vec_t x;
    x.stall = s; x.br = b; x.tgt = t; x.wait_c = w;
    x.pc = pc; x.ins = ins; x.vld = v; x.req = r; x.addr = a;
    return x;
  endfunction

  initial begin
    // zero latency, 1 instr/cycle
    vt[0]  = mk(0, 0, 0,      0, 32'h000, 32'h00A00093, 1, 1, 32'h004);
    vt[1]  = mk(0, 0, 0,      0, 32'h004, 32'h00000413, 1, 1, 32'h008);
    vt[2]  = mk(0, 0, 0,      0, 32'h008, 32'h00000813, 1, 1, 32'h00C);
    vt[3]  = mk(0, 0, 0,      0, 32'h00C, 32'h00000C13, 1, 1, 32'h010);
    // three-cycle memory: two bubbles per fetch, address held
    vt[4]  = mk(0, 0, 0,      2, 32'h00C, NOP,          0, 1, 32'h010);
    vt[5]  = mk(0, 0, 0,      2, 32'h00C, NOP,          0, 1, 32'h010);
    vt[6]  = mk(0, 0, 0,      2, 32'h010, 32'h00001013, 1, 1, 32'h014);
    vt[7]  = mk(0, 0, 0,      2, 32'h010, NOP,          0, 1, 32'h014);
    vt[8]  = mk(0, 0, 0,      2, 32'h010, NOP,          0, 1, 32'h014);
    vt[9]  = mk(0, 0, 0,      2, 32'h014, 32'h00001413, 1, 1, 32'h018);
    // four stall cycles, response lands in the third -> HOLD
    vt[10] = mk(1, 0, 0,      2, 32'h014, 32'h00001413, 1, 1, 32'h018);
    vt[11] = mk(1, 0, 0,      2, 32'h014, 32'h00001413, 1, 1, 32'h018);
    vt[12] = mk(1, 0, 0,      2, 32'h014, 32'h00001413, 1, 0, 32'h01C);
    vt[13] = mk(1, 0, 0,      2, 32'h014, 32'h00001413, 1, 0, 32'h01C);
    vt[14] = mk(0, 0, 0,      2, 32'h018, 32'h00001813, 1, 1, 32'h01C);
    vt[15] = mk(0, 0, 0,      2, 32'h018, NOP,          0, 1, 32'h01C);
    vt[16] = mk(0, 0, 0,      2, 32'h018, NOP,          0, 1, 32'h01C);
    vt[17] = mk(0, 0, 0,      2, 32'h01C, 32'h00001C13, 1, 1, 32'h020);
    // branch to 0x103 with a two-cycle response in flight -> DRAIN
    vt[18] = mk(0, 1, 32'h103, 1, 32'h01C, NOP,         0, 0, 32'h100);
    vt[19] = mk(0, 0, 0,      1, 32'h01C, NOP,          0, 1, 32'h100);
    vt[20] = mk(0, 0, 0,      1, 32'h01C, NOP,          0, 1, 32'h100);
    vt[21] = mk(0, 0, 0,      1, 32'h100, 32'h00010013, 1, 1, 32'h104);
    // stall into HOLD, then branch+stall together
    vt[22] = mk(1, 0, 0,      1, 32'h100, 32'h00010013, 1, 1, 32'h104);
    vt[23] = mk(1, 0, 0,      1, 32'h100, 32'h00010013, 1, 0, 32'h108);
    vt[24] = mk(1, 1, 32'h200, 1, 32'h100, NOP,         0, 1, 32'h200);
    vt[25] = mk(0, 0, 0,      1, 32'h100, NOP,          0, 1, 32'h200);
    vt[26] = mk(0, 0, 0,      1, 32'h200, 32'h00020013, 1, 1, 32'h204);
    // branch in the same cycle as a response: dropped, no DRAIN
    vt[27] = mk(0, 1, 32'h300, 0, 32'h200, NOP,         0, 1, 32'h300);
    vt[28] = mk(0, 0, 0,      0, 32'h300, 32'h00030013, 1, 1, 32'h304);

    // reset state
    #12;
    chk("rst_pc", PC_out, 32'h0);
    chk("rst_pc4", PC4_out, 32'h4);
    chk("rst_instr", instruction_out, NOP);
    chk("rst_valid", {31'h0, valid_out}, 32'h0);
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("wrap_rst_pc", w_pc, 32'hFFFF_FFFC);
    chk("wrap_rst_pc4", w_pc4, 32'h0);

    @(negedge CLK);
    RESETn = 1'b1;
    #1;
    chk("first_req", {31'h0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, 32'h0);

    for (int i = 0; i < NV; i++) begin
      STALL         = vt[i].stall;
      BRANCH_TAKEN  = vt[i].br;
      BRANCH_TARGET = vt[i].tgt;
      mem_wait      = vt[i].wait_c;
      @(posedge CLK);
      #1;
      chk($sformatf("v%0d_pc", i), PC_out, vt[i].pc);
      chk($sformatf("v%0d_pc4", i), PC4_out, vt[i].pc + 32'd4);
      chk($sformatf("v%0d_instr", i), instruction_out, vt[i].ins);
      chk($sformatf("v%0d_valid", i), {31'h0, valid_out}, {31'h0, vt[i].vld});
      chk($sformatf("v%0d_req", i), {31'h0, imem_req}, {31'h0, vt[i].req});
      chk($sformatf("v%0d_addr", i), imem_addr, vt[i].addr);
      if (i == 0) begin
        chk("wrap0_pc", w_pc, 32'hFFFF_FFFC);
        chk("wrap0_pc4", w_pc4, 32'h0);
        chk("wrap0_valid", {31'h0, w_valid}, 32'h1);
        chk("wrap0_addr", w_addr, 32'h0);
      end
      if (i == 1) begin
        chk("wrap1_pc", w_pc, 32'h0);
        chk("wrap1_instr", w_instr, 32'h00A0_0093);
        chk("wrap1_pc4", w_pc4, 32'h4);
      end
      $display("vector %0d: pc=%h instr=%h valid=%0b req=%0b addr=%h",
               i, PC_out, instruction_out, valid_out, imem_req, imem_addr);
      @(negedge CLK);
    end

    // branch with a long response outstanding, then reset pulse mid-DRAIN
    STALL         = 1'b0;
    BRANCH_TAKEN  = 1'b0;
    BRANCH_TARGET = 32'h0;
    mem_wait      = 3;
    @(posedge CLK); #1;
    @(negedge CLK);
    BRANCH_TAKEN  = 1'b1;
    BRANCH_TARGET = 32'h0000_0040;
    @(posedge CLK); #1;
    chk("drain_req", {31'h0, imem_req}, 32'h0);
    chk("drain_valid", {31'h0, valid_out}, 32'h0);
    @(negedge CLK);
    BRANCH_TAKEN = 1'b0;
    #2;
    RESETn = 1'b0;
    #1;
    chk("async_pc", PC_out, 32'h0);
    chk("async_pc4", PC4_out, 32'h4);
    chk("async_instr", instruction_out, NOP);
    chk("async_valid", {31'h0, valid_out}, 32'h0);
    chk("async_req", {31'h0, imem_req}, 32'h0);
    chk("async_addr", imem_addr, 32'h0);
    $display("async reset: pc=%h instr=%h valid=%0b req=%0b",
             PC_out, instruction_out, valid_out, imem_req);
    @(posedge CLK);
    @(negedge CLK);
    RESETn   = 1'b1;
    mem_wait = 0;
    @(posedge CLK); #1;
    chk("rerun_pc", PC_out, 32'h0);
    chk("rerun_instr", instruction_out, 32'h00A0_0093);
    chk("rerun_valid", {31'h0, valid_out}, 32'h1);
    chk("rerun_addr", imem_addr, 32'h4);
    $display("after reset: pc=%h instr=%h valid=%0b addr=%h",
             PC_out, instruction_out, valid_out, imem_addr);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
